// File: rtl/clk_div_ctrl_if.sv
// Config port of clk_div_ctrl: cfg_div offered with a valid/ready handshake.
interface clk_div_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable divider: f_out = clk/(2*(half+1)), ratio and start/stop only at period ends.
// Define CLK_DIV_CTRL_PCNT_EN to add the 16-bit period_cnt output.
module clk_div_ctrl #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    clk_div_ctrl_if.slave cfg,
    output logic          f_out,
    output logic          tick,
    output logic          busy
`ifdef CLK_DIV_CTRL_PCNT_EN
    ,
    output logic [15:0]   period_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] pend;
    logic             pend_vld;
    logic             ready;
    logic             boundary;
    logic             accept;
    logic             apply;

    // Period ends on the last high cycle; f_out falls and tick fires on the next edge.
    assign boundary = (state != IDLE) && (cnt == half) && f_out;
    assign accept   = cfg.cfg_valid && ready;
    assign apply    = pend_vld && ((state == IDLE) || boundary);
    assign cfg.cfg_ready = ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            half     <= CNT_W'(DEF_DIV);
            pend     <= '0;
            pend_vld <= 1'b0;
            ready    <= 1'b1;
            f_out    <= 1'b0;
            tick     <= 1'b0;
            busy     <= 1'b0;
`ifdef CLK_DIV_CTRL_PCNT_EN
            period_cnt <= '0;
`endif
        end else begin
            tick <= boundary;

            unique case (state)
                IDLE: begin
                    cnt   <= '0;
                    f_out <= 1'b0;
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    if (cnt == half) begin
                        cnt   <= '0;
                        f_out <= ~f_out;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    // Stop only at a period end; a dropped en mid-period drains first.
                    if (boundary && !en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!en) begin
                        state <= DRAIN;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // accept and apply never coincide: a pending value holds ready low.
            if (accept) begin
                pend     <= cfg.cfg_div;
                pend_vld <= 1'b1;
                ready    <= 1'b0;
            end
            if (apply) begin
                half     <= pend;
                pend_vld <= 1'b0;
                ready    <= 1'b1;
            end

`ifdef CLK_DIV_CTRL_PCNT_EN
            if (apply)
                period_cnt <= '0;
            else if (boundary)
                period_cnt <= period_cnt + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: phase-position model checked every cycle plus directed literal checks.
module tb_clk_div_ctrl;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 0;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic f_out, tick, busy;
`ifdef CLK_DIV_CTRL_PCNT_EN
    logic [15:0] period_cnt;
`endif

    int total = 0;
    int bad   = 0;

    clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

    clk_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .cfg   (cfg_if),
        .f_out (f_out),
        .tick  (tick),
        .busy  (busy)
`ifdef CLK_DIV_CTRL_PCNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a run is a sequence of periods of 2*(h+1) cycles, low half first.
    // m_pos is the position in the current period; running stops at a period end iff en is low.
    int   m_h, m_pos, m_pend, m_pcnt;
    bit   m_run, m_pvld, m_tick;
    logic m_end, m_app, m_acc;

    assign m_end = m_run && (m_pos == 2 * m_h + 1);
    assign m_app = m_pvld && (!m_run || m_end);
    assign m_acc = cfg_if.cfg_valid && !m_pvld;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_h <= DEF_DIV; m_pos <= 0; m_pend <= 0; m_pcnt <= 0;
            m_run <= 1'b0; m_pvld <= 1'b0; m_tick <= 1'b0;
        end else begin
            m_tick <= m_end;
            if (m_run) begin
                if (m_end) begin
                    m_pos <= 0;
                    if (!en) m_run <= 1'b0;
                end else begin
                    m_pos <= m_pos + 1;
                end
            end else if (en) begin
                m_run <= 1'b1;
                m_pos <= 0;
            end
            if (m_app) begin
                m_h <= m_pend; m_pvld <= 1'b0; m_pcnt <= 0;
            end else if (m_end) begin
                m_pcnt <= (m_pcnt + 1) % 65536;
            end
            if (m_acc) begin
                m_pend <= int'(cfg_if.cfg_div); m_pvld <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        cmp("f_out", f_out, (m_run && m_pos >= m_h + 1) ? 32'd1 : 32'd0);
        cmp("tick", tick, m_tick);
        cmp("busy", busy, m_run);
        cmp("cfg_ready", cfg_if.cfg_ready, !m_pvld);
`ifdef CLK_DIV_CTRL_PCNT_EN
        cmp("period_cnt", period_cnt, m_pcnt);
`endif
    end

    // All tasks below are entered and left just after a falling edge.
    task automatic offer(input int d);
        bit acc;
        int n;
        acc = 1'b0; n = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'(d);
        while (!acc && n < 3000) begin
            acc = cfg_if.cfg_ready;
            @(negedge clk);
            n++;
        end
        cfg_if.cfg_valid = 1'b0;
        cmp("cfg_accept", acc, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        cmp("idle_reached", busy, 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cfg_if.cfg_ready && n < 3000) begin @(negedge clk); n++; end
        cmp("ready_back", cfg_if.cfg_ready, 1);
    endtask

    task automatic tick_gap(output int gap);
        int n = 0;
        gap = -1;
        while (!tick && n < 3000) begin @(negedge clk); n++; end
        if (tick) begin
            @(negedge clk);
            n = 1;
            while (!tick && n < 3000) begin @(negedge clk); n++; end
            if (tick) gap = n;
        end
    endtask

    int gap, hi, n;
    int tab_en[6]   = '{1, 1, 0, 1, 0, 1};
    int tab_div[6]  = '{2, 0, 1, 3, 2, 1};
    int tab_hold[6] = '{3, 7, 5, 2, 9, 4};

    initial begin
        rst = 1'b0; en = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div = '0;
        repeat (2) @(negedge clk);
        cmp("rst_f_out", f_out, 0);
        cmp("rst_tick", tick, 0);
        cmp("rst_busy", busy, 0);
        cmp("rst_cfg_ready", cfg_if.cfg_ready, 1);
        rst = 1'b1;

        // Default half=0: RUN entry, rise one edge later, fall with tick the edge after.
        @(negedge clk); en = 1'b1;
        repeat (3) @(negedge clk);
        cmp("div0_first_fall", f_out, 0);
        cmp("div0_first_tick", tick, 1);
        @(negedge clk);
        cmp("div0_rise", f_out, 1);
        cmp("div0_busy", busy, 1);
`ifdef CLK_DIV_CTRL_PCNT_EN
        repeat (7) @(negedge clk);
        cmp("pcnt_five", period_cnt, 5);
`endif
        tick_gap(gap);
        cmp("period_div0", gap, 2);

        // Ratio change while running waits for a period end.
        offer(1);
        cmp("ready_low_pending", cfg_if.cfg_ready, 0);
        wait_ready();
`ifdef CLK_DIV_CTRL_PCNT_EN
        cmp("pcnt_cleared", period_cnt, 0);
`endif
        tick_gap(gap);
        cmp("period_div1", gap, 4);

        // Ratio change while idle lands on the next edge.
        en = 1'b0;
        wait_idle();
        offer(3);
        cmp("idle_ready_low", cfg_if.cfg_ready, 0);
        @(negedge clk);
        cmp("idle_ready_back", cfg_if.cfg_ready, 1);
        en = 1'b1;
        tick_gap(gap);
        cmp("period_div3", gap, 8);

        // Drop en one cycle into the high phase: high phase still lasts 4 cycles.
        n = 0;
        while (f_out && n < 100) begin @(negedge clk); n++; end
        while (!f_out && n < 200) begin @(negedge clk); n++; end
        cmp("rise_seen", f_out, 1);
        hi = 1;
        n = 0;
        while (n < 100) begin
            @(negedge clk); n++;
            if (!f_out) break;
            hi++;
            if (hi == 2) en = 1'b0;
        end
        cmp("drain_high_len", hi, 4);
        cmp("drain_tick", tick, 1);
        cmp("drain_busy", busy, 0);
        repeat (5) @(negedge clk);
        cmp("drain_held_low", f_out, 0);

        // Async reset with a pending ratio discards it.
        en = 1'b1;
        @(negedge clk);
        offer(5);
        cmp("pend_before_rst", cfg_if.cfg_ready, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        cmp("arst_f_out", f_out, 0);
        cmp("arst_cfg_ready", cfg_if.cfg_ready, 1);
        cmp("arst_busy", busy, 0);
        cmp("arst_tick", tick, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick_gap(gap);
        cmp("period_after_rst", gap, 2 * (DEF_DIV + 1));

        // Full-range ratio.
        en = 1'b0;
        wait_idle();
        offer(255);
        @(negedge clk);
        en = 1'b1;
        tick_gap(gap);
        cmp("period_div255", gap, 512);
        en = 1'b0;
        wait_idle();

        // Mixed en toggling with back-to-back offers; the per-cycle compare covers these.
        for (int i = 0; i < 6; i++) begin
            en = tab_en[i][0];
            offer(tab_div[i]);
            repeat (tab_hold[i]) @(negedge clk);
        end
        en = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
